// File: rtl/console_pkg.sv
// console_pkg: shared types and constants for the buffered DLART console bridge.
package console_pkg;

    // Host-bound (transmit) strobe handshake states
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_STB  = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    // Host-sourced (receive) strobe handshake states
    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_STB  = 2'd1,
        RX_WAIT = 2'd2
    } rx_state_t;

    // Bit positions inside RCSR/XCSR
    localparam int CSR_DONE_BIT = 7;
    localparam int CSR_IE_BIT   = 6;

    // GP code that the bus interface decodes into con_clear
    localparam logic [7:0] GP_CONSOLE_CLR = 8'o014;

endpackage

// File: rtl/console_sync_fifo.sv
// console_sync_fifo: single-clock first-word-fall-through FIFO with flush.
// Pointers carry one extra MSB so full and empty are told apart without a counter.
module console_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

    // Full and empty come from registered pointers, so a pop never makes room
    // for a push in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer next-state: flush wins over any push or pop
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; slots are never read before written.
        if (do_push && !flush_i) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= data_i;
    end

    assign head_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/console_fifo_bridge.sv
// console_fifo_bridge: buffers XBUF writes toward the host (rrdy/rstb) and host
// bytes (wrdy/wstb) toward RBUF, and derives the RCSR/XCSR ready bits.
// Optional feature: define CONSOLE_IRQ_EN for IE bits, rcsr_we/xcsr_we and rx_irq/tx_irq.
module console_fifo_bridge
    import console_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       con_clear,
    input  logic [7:0] cpu_wdata,
    input  logic       xbuf_we,
    input  logic       rbuf_re,
    output logic [7:0] rbuf,
    output logic [7:0] rcsr,
    output logic [7:0] xcsr,
    input  logic       rrdy,
    output logic       rstb,
    input  logic       wrdy,
    output logic       wstb,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       tx_drop
`ifdef CONSOLE_IRQ_EN
    ,
    input  logic       rcsr_we,
    input  logic       xcsr_we,
    output logic       rx_irq,
    output logic       tx_irq
`endif
);

    logic [SYNC_STAGES-1:0] rrdy_sync_q, wrdy_sync_q;
    logic                   rrdy_s, wrdy_s;

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head;

    tx_state_t  tx_state_q, tx_state_d;
    rx_state_t  rx_state_q, rx_state_d;
    logic       rstb_q, rstb_d, wstb_q, wstb_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       tx_drop_q;
    logic       rx_ie, tx_ie;

    // Bring the asynchronous host ready lines into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            rrdy_sync_q <= '0;
            wrdy_sync_q <= '0;
        end else begin
            rrdy_sync_q[0] <= rrdy;
            wrdy_sync_q[0] <= wrdy;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rrdy_sync_q[i] <= rrdy_sync_q[i-1];
                wrdy_sync_q[i] <= wrdy_sync_q[i-1];
            end
        end
    end

    assign rrdy_s = rrdy_sync_q[SYNC_STAGES-1];
    assign wrdy_s = wrdy_sync_q[SYNC_STAGES-1];

    // Full is judged before any same-cycle pop, so a write to a full FIFO is lost
    assign tx_push = xbuf_we && !tx_full;
    assign rx_pop  = rbuf_re && !rx_empty;

    console_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .flush_i (con_clear),
        .data_i  (cpu_wdata),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (tx_head)
    );

    console_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .flush_i (con_clear),
        .data_i  (ad_in),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .head_o  (rx_head)
    );

    // TX handshake state and host-facing output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            rstb_q     <= 1'b0;
            ad_out_q   <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            rstb_q     <= rstb_d;
            ad_out_q   <= ad_out_d;
        end
    end

    // TX next state: offer head when host ready, pop once host drops rrdy
    always_comb begin
        tx_state_d = tx_state_q;
        if (con_clear) begin
            tx_state_d = TX_IDLE;
        end else begin
            case (tx_state_q)
                TX_IDLE: if (!tx_empty && rrdy_s) tx_state_d = TX_STB;
                TX_STB:  if (!rrdy_s)             tx_state_d = TX_WAIT;
                TX_WAIT: if (rrdy_s)              tx_state_d = TX_IDLE;
                default:                          tx_state_d = TX_IDLE;
            endcase
        end
    end

    // TX outputs: load ad_out/rstb on offer, clear rstb and pop on acceptance
    always_comb begin
        rstb_d   = rstb_q;
        ad_out_d = ad_out_q;
        tx_pop   = 1'b0;
        if (con_clear) begin
            rstb_d = 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: if (!tx_empty && rrdy_s) begin
                    rstb_d   = 1'b1;
                    ad_out_d = tx_head;
                end
                TX_STB: if (!rrdy_s) begin
                    rstb_d = 1'b0;
                    tx_pop = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // RX handshake state and strobe register
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            wstb_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            wstb_q     <= wstb_d;
        end
    end

    // RX next state: a full FIFO holds us in idle so the host stalls instead of losing data
    always_comb begin
        rx_state_d = rx_state_q;
        if (con_clear) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE: if (wrdy_s && !rx_full) rx_state_d = RX_STB;
                RX_STB:                          rx_state_d = RX_WAIT;
                RX_WAIT: if (!wrdy_s)            rx_state_d = RX_IDLE;
                default:                         rx_state_d = RX_IDLE;
            endcase
        end
    end

    // RX outputs: one-cycle wstb, byte captured as the strobe ends
    always_comb begin
        wstb_d  = wstb_q;
        rx_push = 1'b0;
        if (con_clear) begin
            wstb_d = 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: if (wrdy_s && !rx_full) wstb_d = 1'b1;
                RX_STB: begin
                    wstb_d  = 1'b0;
                    rx_push = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Overflow indication, one cycle after the discarded write
    always_ff @(posedge clk) begin
        if (rst) tx_drop_q <= 1'b0;
        else     tx_drop_q <= xbuf_we && tx_full;
    end

`ifdef CONSOLE_IRQ_EN
    logic rx_ie_q, tx_ie_q, rx_irq_q, tx_irq_q;

    // IE bits survive con_clear; interrupts are registered enabled-ready conditions
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ie_q  <= 1'b0;
            tx_ie_q  <= 1'b0;
            rx_irq_q <= 1'b0;
            tx_irq_q <= 1'b0;
        end else begin
            if (rcsr_we) rx_ie_q <= cpu_wdata[CSR_IE_BIT];
            if (xcsr_we) tx_ie_q <= cpu_wdata[CSR_IE_BIT];
            rx_irq_q <= rx_ie_q && !rx_empty;
            tx_irq_q <= tx_ie_q && !tx_full;
        end
    end

    assign rx_ie  = rx_ie_q;
    assign tx_ie  = tx_ie_q;
    assign rx_irq = rx_irq_q;
    assign tx_irq = tx_irq_q;
`else
    assign rx_ie = 1'b0;
    assign tx_ie = 1'b0;
`endif

    // CPU-visible status words, straight from FIFO state
    always_comb begin
        rcsr               = 8'h00;
        xcsr               = 8'h00;
        rcsr[CSR_DONE_BIT] = !rx_empty;
        rcsr[CSR_IE_BIT]   = rx_ie;
        xcsr[CSR_DONE_BIT] = !tx_full;
        xcsr[CSR_IE_BIT]   = tx_ie;
    end

    assign rbuf    = rx_empty ? 8'h00 : rx_head;
    assign rstb    = rstb_q;
    assign ad_oe   = rstb_q;
    assign ad_out  = ad_out_q;
    assign wstb    = wstb_q;
    assign tx_drop = tx_drop_q;

endmodule

// File: tb/tb_console_fifo_bridge.sv
// tb_console_fifo_bridge: directed tables, hand-written corner sequences and a
// randomized queue-based scoreboard for console_fifo_bridge.
// Define CONSOLE_IRQ_EN to include the interrupt sequence.
module tb_console_fifo_bridge;
    import console_pkg::*;

    localparam int DL     = 4;
    localparam int SS     = 2;
    localparam int DEPTH  = 1 << DL;
    localparam int N_RAND = 60;

    logic       clk;
    logic       rst;
    logic       con_clear;
    logic [7:0] gp_code;
    logic [7:0] cpu_wdata;
    logic       xbuf_we, rbuf_re;
    logic [7:0] rbuf, rcsr, xcsr;
    logic       rrdy, rstb, wrdy, wstb;
    logic [7:0] ad_in, ad_out;
    logic       ad_oe, tx_drop;
`ifdef CONSOLE_IRQ_EN
    logic       rcsr_we, xcsr_we, rx_irq, tx_irq;
`endif

    // The bus interface turns the console-clear GP code into con_clear
    assign con_clear = (gp_code == GP_CONSOLE_CLR);

    console_fifo_bridge #(.DEPTH_LOG2(DL), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst       (rst),
        .con_clear (con_clear),
        .cpu_wdata (cpu_wdata),
        .xbuf_we   (xbuf_we),
        .rbuf_re   (rbuf_re),
        .rbuf      (rbuf),
        .rcsr      (rcsr),
        .xcsr      (xcsr),
        .rrdy      (rrdy),
        .rstb      (rstb),
        .wrdy      (wrdy),
        .wstb      (wstb),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .tx_drop   (tx_drop)
`ifdef CONSOLE_IRQ_EN
        ,
        .rcsr_we   (rcsr_we),
        .xcsr_we   (xcsr_we),
        .rx_irq    (rx_irq),
        .tx_irq    (tx_irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_xcsr;
        logic       exp_drop;
    } wr_vec_t;

    wr_vec_t fill_tab[DEPTH+1];

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int tx_wr, tx_rcvd, rx_rd, drops;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rstb(input logic val, input int max_cyc, input string name);
        int n = 0;
        while (rstb !== val && n < max_cyc) begin
            tick();
            n++;
        end
        check(name, 32'(rstb === val), 32'd1);
    endtask

    task automatic wait_wstb(input logic val, input int max_cyc, input string name);
        int n = 0;
        while (wstb !== val && n < max_cyc) begin
            tick();
            n++;
        end
        check(name, 32'(wstb === val), 32'd1);
    endtask

    task automatic cpu_write(input logic [7:0] b);
        cpu_wdata = b;
        xbuf_we   = 1'b1;
        tick();
        xbuf_we   = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] exp, input string name);
        rrdy = 1'b1;
        wait_rstb(1'b1, 40, {name, "_tmo"});
        check(name, 32'(ad_out), 32'(exp));
        rrdy = 1'b0;
        wait_rstb(1'b0, 40, {name, "_rel"});
    endtask

    task automatic host_write(input logic [7:0] b);
        ad_in = b;
        wrdy  = 1'b1;
        wait_wstb(1'b1, 40, "hw_tmo");
        tick();
        wrdy = 1'b0;
        repeat (SS + 2) tick();
    endtask

    task automatic count_rstb(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            tick();
            if (rstb === 1'b1) seen++;
        end
    endtask

    initial begin
        int n;
        int seen;

        for (int i = 0; i <= DEPTH; i++) begin
            fill_tab[i].data     = 8'(i);
            fill_tab[i].exp_xcsr = (i + 1 >= DEPTH) ? 8'h00 : 8'h80;
            fill_tab[i].exp_drop = (i == DEPTH);
        end

        rst = 1'b1; gp_code = 8'h00; cpu_wdata = 8'h00; xbuf_we = 1'b0; rbuf_re = 1'b0;
        rrdy = 1'b0; wrdy = 1'b0; ad_in = 8'h00;
`ifdef CONSOLE_IRQ_EN
        rcsr_we = 1'b0; xcsr_we = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_xcsr", 32'(xcsr), 'h80);
        check("rst_rcsr", 32'(rcsr), 'h00);
        check("rst_rbuf", 32'(rbuf), 'h00);
        check("rst_rstb", 32'(rstb), 'h0);
        check("rst_wstb", 32'(wstb), 'h0);
        check("rst_ad_oe", 32'(ad_oe), 'h0);
        check("rst_ad_out", 32'(ad_out), 'h00);
        check("rst_tx_drop", 32'(tx_drop), 'h0);

        // Single byte to host: latency from rrdy rising to rstb
        cpu_write(8'h41);
        check("wr1_xcsr", 32'(xcsr), 'h80);
        count_rstb(4, seen);
        check("wr1_no_rstb_while_rrdy_low", 32'(seen), 'd0);
        rrdy = 1'b1;
        n = 0;
        while (rstb !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wr1_rstb_latency", 32'(n), 32'(SS + 1));
        check("wr1_ad_out", 32'(ad_out), 'h41);
        check("wr1_ad_oe", 32'(ad_oe), 'h1);
        rrdy = 1'b0;
        wait_rstb(1'b0, 20, "wr1_rstb_fall");
        check("wr1_ad_oe_off", 32'(ad_oe), 'h0);

        // Fill TX past capacity with the host stalled
        for (int i = 0; i <= DEPTH; i++) begin
            cpu_wdata = fill_tab[i].data;
            xbuf_we   = 1'b1;
            tick();
            check($sformatf("fill_xcsr_%0d", i), 32'(xcsr), 32'(fill_tab[i].exp_xcsr));
            check($sformatf("fill_drop_%0d", i), 32'(tx_drop), 32'(fill_tab[i].exp_drop));
        end
        xbuf_we = 1'b0;
        tick();
        check("fill_drop_one_cycle", 32'(tx_drop), 'h0);
        for (int i = 0; i < DEPTH; i++) host_read(8'(i), $sformatf("drain_%0d", i));
        check("drain_xcsr", 32'(xcsr), 'h80);
        rrdy = 1'b1;
        count_rstb(8, seen);
        check("drain_no_extra_byte", 32'(seen), 'd0);
        rrdy = 1'b0;
        repeat (SS + 2) tick();

        // One host byte through the wrdy handshake
        ad_in = 8'h0D;
        wrdy  = 1'b1;
        wait_wstb(1'b1, 20, "rx1_wstb");
        check("rx1_rcsr_before_push", 32'(rcsr), 'h00);
        tick();
        check("rx1_wstb_one_cycle", 32'(wstb), 'h0);
        check("rx1_rcsr", 32'(rcsr), 'h80);
        check("rx1_rbuf", 32'(rbuf), 'h0D);
        wrdy = 1'b0;
        repeat (SS + 2) tick();
        check("rx1_no_second_wstb", 32'(wstb), 'h0);
        rbuf_re = 1'b1;
        tick();
        rbuf_re = 1'b0;
        check("rx1_rcsr_after_read", 32'(rcsr), 'h00);
        check("rx1_rbuf_after_read", 32'(rbuf), 'h00);
        rbuf_re = 1'b1;
        tick();
        rbuf_re = 1'b0;
        check("rx_empty_read_rcsr", 32'(rcsr), 'h00);
        check("rx_empty_read_rbuf", 32'(rbuf), 'h00);

        // Host offers DEPTH+1 bytes with no CPU reads
        for (int i = 0; i < DEPTH; i++) host_write(8'(8'h80 + i));
        check("rxfill_rcsr", 32'(rcsr), 'h80);
        ad_in = 8'h90;
        wrdy  = 1'b1;
        seen  = 0;
        repeat (12) begin
            tick();
            if (wstb === 1'b1) seen++;
        end
        check("rxfill_stall", 32'(seen), 'd0);
        check("rxfill_head", 32'(rbuf), 'h80);
        rbuf_re = 1'b1;
        tick();
        rbuf_re = 1'b0;
        check("rxfill_head_after_pop", 32'(rbuf), 'h81);
        wait_wstb(1'b1, 20, "rxfill_resume");
        tick();
        wrdy = 1'b0;
        repeat (SS + 2) tick();
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("rxdrain_%0d", i), 32'(rbuf), 32'(8'h81 + i));
            rbuf_re = 1'b1;
            tick();
            rbuf_re = 1'b0;
        end
        check("rxdrain_rcsr", 32'(rcsr), 'h00);
        check("rxdrain_rbuf", 32'(rbuf), 'h00);

        // Console clear while a byte is being offered with more queued
        cpu_write(8'hA1);
        cpu_write(8'hA2);
        cpu_write(8'hA3);
        host_write(8'h55);
        check("clr_pre_rcsr", 32'(rcsr), 'h80);
        rrdy = 1'b1;
        wait_rstb(1'b1, 20, "clr_rstb");
        check("clr_pre_ad_out", 32'(ad_out), 'hA1);
        gp_code = GP_CONSOLE_CLR;
        tick();
        gp_code = 8'h00;
        check("clr_rstb", 32'(rstb), 'h0);
        check("clr_ad_oe", 32'(ad_oe), 'h0);
        check("clr_xcsr", 32'(xcsr), 'h80);
        check("clr_rcsr", 32'(rcsr), 'h00);
        check("clr_rbuf", 32'(rbuf), 'h00);
        count_rstb(6, seen);
        check("clr_tx_flushed", 32'(seen), 'd0);
        cpu_write(8'hB7);
        wait_rstb(1'b1, 20, "clr_after_rstb");
        check("clr_after_ad_out", 32'(ad_out), 'hB7);
        rrdy = 1'b0;
        wait_rstb(1'b0, 20, "clr_after_rel");

        // Reset in the middle of a handshake
        rrdy = 1'b1;
        cpu_write(8'hC3);
        wait_rstb(1'b1, 20, "mid_rst_rstb");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rstb_low", 32'(rstb), 'h0);
        check("mid_rst_ad_out", 32'(ad_out), 'h00);
        check("mid_rst_xcsr", 32'(xcsr), 'h80);
        rrdy = 1'b0;
        repeat (SS + 2) tick();

`ifdef CONSOLE_IRQ_EN
        // Interrupt enables and registered interrupt lines
        cpu_wdata = 8'h40;
        xcsr_we   = 1'b1;
        tick();
        xcsr_we = 1'b0;
        check("irq_xcsr_ie", 32'(xcsr), 'hC0);
        tick();
        check("irq_tx_on", 32'(tx_irq), 'h1);
        cpu_wdata = 8'h40;
        rcsr_we   = 1'b1;
        tick();
        rcsr_we = 1'b0;
        check("irq_rcsr_ie", 32'(rcsr), 'h40);
        tick();
        check("irq_rx_idle", 32'(rx_irq), 'h0);
        for (int i = 0; i < DEPTH; i++) cpu_write(8'(i));
        check("irq_full_xcsr", 32'(xcsr), 'h40);
        tick();
        check("irq_tx_off", 32'(tx_irq), 'h0);
        gp_code = GP_CONSOLE_CLR;
        tick();
        gp_code = 8'h00;
        check("irq_ie_kept_x", 32'(xcsr), 'hC0);
        check("irq_ie_kept_r", 32'(rcsr), 'h40);
        host_write(8'h11);
        check("irq_rx_on", 32'(rx_irq), 'h1);
        rbuf_re = 1'b1;
        tick();
        rbuf_re = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        // Randomized traffic in both directions against queue scoreboards
        tx_wr = 0; tx_rcvd = 0; rx_rd = 0; drops = 0;
        fork
            begin : cpu_proc
                int cyc = 0;
                int rd_prob;
                logic [7:0] cb;
                while ((tx_wr < N_RAND || rx_rd < N_RAND) && cyc < 20000) begin
                    xbuf_we = 1'b0;
                    rbuf_re = 1'b0;
                    rd_prob = (cyc < 1500) ? 30 : 3;
                    if (tx_wr < N_RAND && xcsr[CSR_DONE_BIT] && $urandom_range(0, 2) == 0) begin
                        cb        = 8'($urandom);
                        cpu_wdata = cb;
                        xbuf_we   = 1'b1;
                        tx_exp.push_back(cb);
                        tx_wr++;
                    end
                    if (rcsr[CSR_DONE_BIT]) begin
                        if ($urandom_range(0, rd_prob) == 0) begin
                            if (rx_exp.size() == 0) check("rnd_rx_phantom", 32'd1, 32'd0);
                            else check("rnd_rbuf", 32'(rbuf), 32'(rx_exp.pop_front()));
                            rbuf_re = 1'b1;
                            rx_rd++;
                        end
                    end else begin
                        check("rnd_rbuf_empty", 32'(rbuf), 'h00);
                    end
                    if (tx_drop === 1'b1) drops++;
                    tick();
                    cyc++;
                end
                xbuf_we = 1'b0;
                rbuf_re = 1'b0;
            end
            begin : host_tx_proc
                int w;
                while (tx_rcvd < N_RAND) begin
                    repeat ($urandom_range(0, 3)) tick();
                    rrdy = 1'b1;
                    w = 0;
                    while (rstb !== 1'b1 && w < 5000) begin
                        tick();
                        w++;
                    end
                    if (rstb !== 1'b1) begin
                        check("rnd_tx_timeout", 32'd0, 32'd1);
                        break;
                    end
                    if (tx_exp.size() == 0) check("rnd_tx_phantom", 32'd1, 32'd0);
                    else check("rnd_tx_data", 32'(ad_out), 32'(tx_exp.pop_front()));
                    tx_rcvd++;
                    rrdy = 1'b0;
                    wait_rstb(1'b0, 40, "rnd_tx_rel");
                end
                rrdy = 1'b0;
            end
            begin : host_rx_proc
                int w;
                logic [7:0] hb;
                for (int i = 0; i < N_RAND; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    hb    = 8'($urandom);
                    ad_in = hb;
                    wrdy  = 1'b1;
                    w = 0;
                    while (wstb !== 1'b1 && w < 5000) begin
                        tick();
                        w++;
                    end
                    if (wstb !== 1'b1) begin
                        check("rnd_rx_timeout", 32'd0, 32'd1);
                        break;
                    end
                    rx_exp.push_back(hb);
                    tick();
                    wrdy = 1'b0;
                    repeat (SS + 2) tick();
                end
                wrdy = 1'b0;
            end
        join

        check("rnd_tx_count", 32'(tx_rcvd), 32'(N_RAND));
        check("rnd_rx_count", 32'(rx_rd), 32'(N_RAND));
        check("rnd_tx_left", 32'(tx_exp.size()), 32'd0);
        check("rnd_rx_left", 32'(rx_exp.size()), 32'd0);
        check("rnd_no_drops", 32'(drops), 32'd0);
        check("rnd_end_xcsr", 32'(xcsr), 'h80);
        check("rnd_end_rcsr", 32'(rcsr), 'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/console_fifo_bridge.md
# console_fifo_bridge

Buffered DLART console bridge between the DCJ11 bus interface and the host-side ODT strobe port (rrdy/rstb, wrdy/wstb, ad). CPU writes to XBUF land in a transmit FIFO that drains to the host. Host bytes land in a receive FIFO that the CPU drains through RBUF. The block derives RCSR/XCSR ready bits from FIFO state and replaces the single-byte rdata/wdata handoff in the bus interface.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth exponent; each FIFO holds 2**DEPTH_LOG2 bytes.
- SYNC_STAGES, 2: synchronizer flops on rrdy and wrdy.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- con_clear  in  1  console reset (GP code 014); synchronous flush.
- cpu_wdata  in  8  CPU write data (DAL low byte).
- xbuf_we  in  1  one-cycle strobe: write XBUF.
- rbuf_re  in  1  one-cycle strobe: read RBUF (pops).
- rbuf  out  8  RX FIFO head (first-word-fall-through); 0 when empty.
- rcsr  out  8  bit7 = RX not empty; bit6 = RX IE (macro); others 0.
- xcsr  out  8  bit7 = TX not full; bit6 = TX IE (macro); others 0.
- rrdy  in  1  host ready to accept a byte (asynchronous).
- rstb  out  1  byte valid to host.
- wrdy  in  1  host has a byte (asynchronous).
- wstb  out  1  strobe to host for a byte.
- ad_in  in  8  host data in.
- ad_out  out  8  data to host.
- ad_oe  out  1  drive enable for ad; equals rstb.
- tx_drop  out  1  one-cycle pulse: XBUF write discarded (FIFO full).

## Operation
- Reset values: rstb=0, wstb=0, ad_oe=0, ad_out=0, tx_drop=0. Both FIFOs empty, so rcsr=0x00, xcsr=0x80, rbuf=0x00. IE bits are 0.
- TX FIFO:
  - xbuf_we with TX not full pushes cpu_wdata[7:0].
  - xbuf_we with TX full is discarded and pulses tx_drop.
  - Full is evaluated before a same-cycle pop, so a write to a full FIFO is dropped even if the host pops that cycle.
- TX FSM, states TX_IDLE, TX_STB, TX_WAIT:
  - TX_IDLE to TX_STB when TX not empty and rrdy_s=1. In the same edge: ad_out=head, rstb=1.
  - TX_STB to TX_WAIT when rrdy_s=0. In the same edge: pop, rstb=0.
  - TX_WAIT to TX_IDLE when rrdy_s=1.
- RX FSM, states RX_IDLE, RX_STB, RX_WAIT:
  - RX_IDLE to RX_STB when wrdy_s=1 and RX not full. In the same edge: wstb=1.
  - RX_STB lasts exactly one cycle, then goes to RX_WAIT. In the same edge: push ad_in, wstb=0.
  - RX_WAIT to RX_IDLE when wrdy_s=0.
  - RX full blocks in RX_IDLE. The host stalls and no byte is lost.
- rbuf_re when RX empty: no pop, no state change.
- Simultaneous push and pop on either FIFO when not full and not empty: both happen, count unchanged.
- con_clear: both FIFOs emptied, both FSMs to IDLE, rstb=wstb=0 next edge. IE bits are kept.
- rst: all state returns to reset values at the next edge, even mid-handshake.

## Timing
- rrdy_s and wrdy_s lag the pins by SYNC_STAGES cycles.
- XBUF write to rstb=1: 1 cycle (push) + 1 cycle (FSM), given rrdy_s=1.
- Host push to rcsr bit7=1: visible the cycle after the RX_STB edge.
- rbuf and status bits are combinational from FIFO registers. There is no read latency.
- Pointers are DEPTH_LOG2+1 bits wide. The extra MSB distinguishes full from empty and wraps naturally.

## Configuration
- CONSOLE_IRQ_EN defined:
  - Adds inputs rcsr_we, xcsr_we: write cpu_wdata[6] to the respective IE bit.
  - Adds outputs rx_irq = RX IE & RX not empty, tx_irq = TX IE & TX not full. Both are registered, 1-cycle latency, reset 0.
- CONSOLE_IRQ_EN undefined: the ports are absent and bit6 of rcsr/xcsr reads 0.

## Structure
- Package console_pkg holds:
  - tx_state_t and rx_state_t enums.
  - CSR_DONE_BIT=7 and CSR_IE_BIT=6.
  - GP_CONSOLE_CLR=8'o014.
- Sub-module console_sync_fifo, instantiated twice:
  - Parameterized width and depth.
  - push, pop, flush, full, empty, head.

## Test plan
- Reset with rrdy=0: xcsr=0x80, rcsr=0x00, rstb=0. Write 0x41 to XBUF: xcsr stays 0x80. Raise rrdy: rstb=1 with ad_out=0x41 after SYNC_STAGES+1 cycles.
- Write 0x00..0x10 (17 bytes) with rrdy=0, DEPTH_LOG2=4: xcsr bit7=0 after the 16th write. The 17th write pulses tx_drop. The host then reads 0x00..0x0F in order.
- Host writes 0x0D via the wrdy handshake: one wstb pulse of 1 cycle, rcsr=0x80, rbuf=0x0D. rbuf_re gives rcsr=0x00.
- Host offers 17 bytes without CPU reads: 16 accepted, the 17th stalls with wstb=0. One rbuf_re lets the 17th be accepted.
- Assert con_clear while TX_STB is active with 3 bytes queued: next cycle rstb=0, xcsr=0x80, rcsr=0x00.
- With CONSOLE_IRQ_EN: xcsr_we with cpu_wdata=0x40 gives tx_irq=1 next cycle. Fill TX: tx_irq=0.
